// File: rtl/apb_bcd_pkg.sv
// Shared types and helpers for the APB BCD subtractor master: FSM states, transfer steps,
// response codes and the packed-BCD digit check.
package apb_bcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SETUP,
    ACCESS,
    GAP,
    SETTLE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    WR_A,
    WR_B,
    WR_CTRL,
    RD_RES
  } step_t;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_BADBCD  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  // True when all three nibbles of a packed-BCD value are decimal digits.
  function automatic logic is_bcd12(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

endpackage

// File: rtl/apb_xfer.sv
// Single APB transfer engine: SETUP, ACCESS (with PREADY timeout) and a mandatory GAP cycle.
// Handshake: start is honoured in IDLE or GAP; done is high for the GAP cycle; timeout is high
// in the last ACCESS cycle that expires, and the bus drops at the following edge.
module apb_xfer
  import apb_bcd_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        start_wr,
  input  logic [31:0] start_addr,
  input  logic [31:0] start_wdata,
  output logic        done,
  output logic        timeout,
  output logic [11:0] rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          unused_prdata_hi;

  assign unused_prdata_hi = ^PRDATA[31:12];

  assign done    = (state == GAP);
  assign timeout = (state == ACCESS) && !PREADY && (tcnt == TMAX);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      tcnt    <= '0;
      rdata   <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (start) begin
            state  <= SETUP;
            PSEL   <= 1'b1;
            PWRITE <= start_wr;
            PADDR  <= start_addr;
            PWDATA <= start_wdata;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          tcnt    <= '0;
        end
        ACCESS: begin
          // PREADY is only meaningful here; the GAP that follows masks a lingering PREADY.
          if (PREADY) begin
            state   <= GAP;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (!PWRITE) rdata <= PRDATA[11:0];
          end else if (tcnt == TMAX) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_bcd_master.sv
// APB master that sequences write A, write B, write control, settle and read result against the
// BCD subtractor slave, returning the BCD difference or an error code.
module apb_bcd_master
  import apb_bcd_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR     = 32'h0,
  parameter logic [31:0] OPA_ADDR      = 32'h4,
  parameter logic [31:0] OPB_ADDR      = 32'h8,
  parameter logic [31:0] RES_ADDR      = 32'hC,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          TIMEOUT       = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_a,
  input  logic [11:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [11:0] rsp_data,
  output logic [1:0]  rsp_code,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYCLES - 1);

  // Valid/ready: a beat moves on the edge where both are high. req_ready is high only in IDLE;
  // rsp_valid, rsp_data and rsp_code hold until rsp_ready is sampled high in RESP.

  // SETUP here means "a transfer is in flight in apb_xfer"; ACCESS and GAP live in the engine.
  state_t        state;
  step_t         step;
  step_t         start_step;
  logic [11:0]   a_q;
  logic [11:0]   b_q;
  logic [SW-1:0] settle_cnt;
  logic          bcd_ok;
  logic          start;
  logic          start_wr;
  logic [31:0]   start_addr;
  logic [31:0]   start_wdata;
  logic          xfer_done;
  logic          xfer_timeout;
  logic [11:0]   xfer_rdata;

  assign bcd_ok = is_bcd12(a_q) && is_bcd12(b_q);

  // The next transfer is launched in the same cycle the previous one sits in GAP.
  always_comb begin
    start      = 1'b0;
    start_step = WR_A;
    case (state)
      CHECK: start = bcd_ok;
      SETUP: begin
        if (xfer_done && (step == WR_A || step == WR_B)) begin
          start      = 1'b1;
          start_step = (step == WR_A) ? WR_B : WR_CTRL;
        end
      end
      SETTLE: begin
        if (settle_cnt == SMAX) begin
          start      = 1'b1;
          start_step = RD_RES;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    start_wr    = 1'b1;
    start_addr  = OPA_ADDR;
    start_wdata = {20'b0, a_q};
    case (start_step)
      WR_B: begin
        start_addr  = OPB_ADDR;
        start_wdata = {20'b0, b_q};
      end
      WR_CTRL: begin
        start_addr  = CTRL_ADDR;
        start_wdata = 32'h1;
      end
      RD_RES: begin
        start_wr    = 1'b0;
        start_addr  = RES_ADDR;
        start_wdata = 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      step       <= WR_A;
      a_q        <= '0;
      b_q        <= '0;
      settle_cnt <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_code   <= RSP_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            a_q       <= req_a;
            b_q       <= req_b;
            req_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (bcd_ok) begin
            step  <= WR_A;
            state <= SETUP;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_code  <= RSP_BADBCD;
            state     <= RESP;
          end
        end
        SETUP: begin
          if (xfer_timeout) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_code  <= RSP_TIMEOUT;
            state     <= RESP;
          end else if (xfer_done) begin
            case (step)
              WR_A: step <= WR_B;
              WR_B: step <= WR_CTRL;
              WR_CTRL: begin
                settle_cnt <= '0;
                state      <= SETTLE;
              end
              RD_RES: begin
                rsp_valid <= 1'b1;
                rsp_data  <= xfer_rdata;
                rsp_code  <= RSP_OK;
                state     <= RESP;
              end
              default: state <= IDLE;
            endcase
          end
        end
        SETTLE: begin
          if (settle_cnt == SMAX) begin
            step  <= RD_RES;
            state <= SETUP;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_xfer #(
    .TIMEOUT(TIMEOUT)
  ) u_xfer (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .start      (start),
    .start_wr   (start_wr),
    .start_addr (start_addr),
    .start_wdata(start_wdata),
    .done       (xfer_done),
    .timeout    (xfer_timeout),
    .rdata      (xfer_rdata),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY)
  );

endmodule
